// File: rtl/fifo_write_arbiter_pkg.sv
// fifo_write_arbiter_pkg: shared state type and width helper for the FIFO write arbiter
package fifo_write_arbiter_pkg;
  typedef enum logic {IDLE, HOLD} arb_state_t;
  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/fifo_write_arbiter_if.sv
// fifo_write_arbiter_if: producer request bus plus FIFO write port shared through the arbiter
interface fifo_write_arbiter_if
  import fifo_write_arbiter_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 16
);
  logic [N_REQ-1:0]        req;
  logic [N_REQ-1:0]        ack;
  logic [N_REQ*DATA_W-1:0] data;
  logic                    fifo_full;
  logic                    w_req;
  logic [DATA_W-1:0]       w_data;
  logic                    busy;
  logic [cw(N_REQ)-1:0]    grant_id;
  modport master (output req, data, fifo_full, input ack, w_req, w_data, busy, grant_id);
  modport slave  (input req, data, fifo_full, output ack, w_req, w_data, busy, grant_id);
endinterface

// File: rtl/rr_priority_pick.sv
// rr_priority_pick: first set request after the last pointer, wrapping; the last pointer itself is examined last
module rr_priority_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] last_i,
  output logic [W-1:0] pick_o,
  output logic         valid_o
);
  logic [W-1:0] idx;
  // scanning from the farthest offset down lets the nearest set bit win
  always_comb begin
    pick_o = last_i;
    idx = last_i;
    for (int i = N; i >= 1; i--) begin
      idx = W'((int'(last_i) + i) % N);
      if (req_i[idx]) pick_o = idx;
    end
  end
  assign valid_o = |req_i;
endmodule

// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin sharing of one FIFO write port among N_REQ producers,
// holding each grant for bursts of up to BURST_LEN accepted words.
module fifo_write_arbiter
  import fifo_write_arbiter_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 16,
  parameter int BURST_LEN = 4
) (
  input logic clk,
  input logic nrst,
  fifo_write_arbiter_if.slave bus
);
  localparam int GW = cw(N_REQ);
  localparam int BW = cw(BURST_LEN + 1);
  arb_state_t    state_q, state_d;
  logic [GW-1:0] grant_q, grant_d, pick;
  logic [BW-1:0] cnt_q, cnt_d;
  logic          any, hold, req_g, wr, expire;
  rr_priority_pick #(.N(N_REQ), .W(GW)) u_pick (
    .req_i  (bus.req),
    .last_i (grant_q),
    .pick_o (pick),
    .valid_o(any)
  );
  assign hold   = state_q == HOLD;
  assign req_g  = bus.req[grant_q];
  assign wr     = hold & req_g & ~bus.fifo_full;
  assign expire = ~req_g | (wr & (cnt_q == BW'(BURST_LEN - 1)));
  assign bus.w_req    = wr;
  assign bus.ack      = {{(N_REQ-1){1'b0}}, wr} << grant_q;
  assign bus.w_data   = hold ? bus.data[int'(grant_q)*DATA_W +: DATA_W] : '0;
  assign bus.busy     = hold;
  assign bus.grant_id = grant_q;
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      grant_q <= GW'(N_REQ - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
    end
  end
  // a dropped grant has req[grant]=0 already, so the raw req vector is the candidate set
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    if (!hold) begin
      state_d = any ? HOLD : IDLE;
      grant_d = any ? pick : grant_q;
      cnt_d   = '0;
    end else if (!expire) begin
      cnt_d = cnt_q + BW'(wr);
    end else begin
      state_d = any ? HOLD : IDLE;
      grant_d = any ? pick : grant_q;
      cnt_d   = '0;
    end
  end
endmodule

// File: doc/fifo_write_arbiter.md
Name: fifo_write_arbiter

Overview:
- Round-robin arbiter that shares the single write port of one fifo_single_clock_reg_v2 instance (w_req / w_data / full) between N_REQ independent producers.
- Grants are held for bounded bursts to amortise arbitration.
- Full-flag backpressure is passed straight through to the granted producer.
- Sits between producer blocks and the FIFO, in the FIFO's clock domain.

Parameters:
- N_REQ, 4, number of requesters; must be >=2.
- DATA_W, 16, word width; must match the FIFO DATA_W.
- BURST_LEN, 4, maximum accepted words per grant before forced re-arbitration; must be >=1.

Ports:
- clk  in  1  system clock, rising edge.
- nrst  in  1  reset, asynchronous and active-low.
- req  in  N_REQ  per-requester request; held high while the requester has a word.
- data  in  N_REQ*DATA_W  packed request data; requester i occupies bits [i*DATA_W +: DATA_W].
- ack  out  N_REQ  one-hot; high on the cycle requester i's word is written; the requester then advances its data.
- fifo_full  in  1  FIFO full flag.
- w_req  out  1  FIFO write strobe.
- w_data  out  DATA_W  FIFO write data.
- busy  out  1  high in HOLD.
- grant_id  out  $clog2(N_REQ)  current or last granted requester.

Behaviour:
- State register: IDLE / HOLD. Registers: grant_id, burst_cnt ($clog2(BURST_LEN+1) bits).
- Asynchronous reset (nrst=0), effective immediately, not on the next edge:
  - state=IDLE, grant_id=N_REQ-1 (so requester 0 wins first), burst_cnt=0.
  - w_req=0, ack=0, busy=0, w_data=0.
- Combinational outputs, valid only in HOLD:
  - w_req = req[grant_id] & ~fifo_full.
  - ack = w_req << grant_id.
  - w_data = data slice of grant_id.
- Outside HOLD: w_req=0, ack=0, w_data=0.
- Handshake:
  - A requester keeps req and data stable until it sees ack.
  - It may drop req without ack (withdraw), with no penalty.
  - ack never asserts for a non-granted requester.
- RR pick:
  - Candidate is the first set req bit scanning from grant_id+1 upward, wrapping modulo N_REQ.
  - The current grant_id is examined last.
- IDLE:
  - req==0: stay in IDLE.
  - Otherwise, on the next edge: grant_id=pick, state=HOLD, burst_cnt=0.
  - Arbitration latency is 1 cycle; no write occurs in the IDLE cycle.
- HOLD, exit condition E = (~req[grant_id]) | (w_req & burst_cnt==BURST_LEN-1).
  - ~E: burst_cnt += w_req; stay in HOLD.
  - E with (req masked to exclude a dropped grant)!=0: grant_id=pick, burst_cnt=0, stay in HOLD. This is back-to-back re-arbitration with no IDLE bubble.
  - A burst-expired grantee that still requests is re-granted only if no other req is set.
  - E with no candidates: state=IDLE; grant_id is retained as the RR pointer.
- Full:
  - fifo_full=1 forces w_req=0 and freezes burst_cnt. The grant is kept indefinitely; there is no timeout.
  - Grant remains revocable by req drop.
  - Writes on the cycle full falls resume immediately.
- BURST_LEN=1: every accepted word triggers re-arbitration.
- Throughput: with req held and FIFO not full, exactly 1 word per clk.
- Reset mid-burst: the partial burst is abandoned. The word presented on the reset cycle is not acked and is not written.

Decomposition:
- Package fifo_write_arbiter_pkg:
  - typedef enum logic {IDLE, HOLD} arb_state_t.
  - Function clog2-safe width helper for grant_id/burst_cnt.
- Sub-module rr_priority_pick:
  - Combinational.
  - Inputs: req mask, last pointer.
  - Outputs: pick index and any-valid.
  - Reusable by other arbiters in the codebase.

Test Plan:
- Reset, then req=4'b0001 held, FIFO DEPTH 8 empty.
  - Grant to 0 one cycle after req; ack[0] on 4 consecutive cycles, then re-grant to 0 with no bubble.
  - 8 words land in the FIFO; full=1, w_req=0; grant_id stays 0.
- req=4'b1111 continuously, FIFO drained every cycle.
  - Grant order 0,1,2,3,0..., 4 words each.
  - w_data matches the granted requester's slice; no cycle without w_req after the first grant.
- req=4'b0110, with requester 2 dropping req after 2 acks.
  - Grant 1 (4 words), 2 (2 words), 1 (4 words).
  - Grant switches on the cycle after the drop; no ack to 2 after its drop.
- Granted requester with FIFO full for 10 cycles.
  - w_req=0 and ack=0 for the full 10 cycles; burst_cnt frozen.
  - Remaining burst words are written after full deasserts; total per grant is still 4.
- Assert nrst=0 asynchronously mid-burst (between edges).
  - w_req, ack and busy go to 0 immediately.
  - After release with req=4'b1000: first grant is to 3 and the FIFO contents continue without a duplicate word.
- BURST_LEN=1 build, req=4'b0101.
  - Acks alternate 0,2,0,2 every cycle; grant_id toggles every cycle.
